coreir_mem_rv: RTL and testbench

Parametrised single-clock memory with a masked write port and a valid/ready read port supporting configurable read latency, backpressure and optional initial contents. Next-generation replacement for the plain memory primitive wherever a consumer may stall: read responses are buffered internally and returned strictly in request order. Sits between datapath producers (write side) and stall-capable consumers such as stream engines or lookup pipelines.

---
 rtl/coreir_mem_rv_if.sv | 49 ++++
 rtl/coreir_mem_rv.sv | 153 +++++++++++++++
 tb/tb_coreir_mem_rv.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coreir_mem_rv_if.sv
// -----------------------------------------------------------------------------
// coreir_mem_rv_if
// Bundles the write port and the valid/ready read request/response channels of
// coreir_mem_rv. Clock and reset are kept as plain ports on the memory itself.
//
// Signals:
//   wen, waddr, wdata, wmask       masked write port (never stalls)
//   rreq_valid, rreq_ready, raddr  read request handshake
//   rresp_valid, rresp_ready, rdata read response handshake
//
// Modports:
//   master  - producer/consumer side (drives write port, requests, resp ready)
//   slave   - memory side
// -----------------------------------------------------------------------------
interface coreir_mem_rv_if #(
    parameter int unsigned width = 16,
    parameter int unsigned depth = 16
);
    localparam int unsigned addr_w = $clog2(depth);

    logic              wen;
    logic [addr_w-1:0] waddr;
    logic [width-1:0]  wdata;
    logic [width-1:0]  wmask;

    logic              rreq_valid;
    logic              rreq_ready;
    logic [addr_w-1:0] raddr;

    logic              rresp_valid;
    logic              rresp_ready;
    logic [width-1:0]  rdata;

    modport master (
        output wen, waddr, wdata, wmask,
        output rreq_valid, raddr,
        input  rreq_ready,
        input  rresp_valid, rdata,
        output rresp_ready
    );

    modport slave (
        input  wen, waddr, wdata, wmask,
        input  rreq_valid, raddr,
        output rreq_ready,
        output rresp_valid, rdata,
        input  rresp_ready
    );
endinterface

// File: rtl/coreir_mem_rv.sv
// -----------------------------------------------------------------------------
// coreir_mem_rv
// Single-clock memory with a masked write port and a valid/ready read port.
// Reads are accepted against a credit counter, travel through a read_latency
// stage pipeline and land in a (read_latency+1)-entry response FIFO, so a
// stalled consumer never loses data and responses stay in request order.
//
// Ports:
//   clk    - clock, everything on the rising edge
//   rst_n  - synchronous active-low reset (clears pipeline, FIFO, credits;
//            memory contents are kept)
//   bus    - coreir_mem_rv_if.slave (write port, read request, read response)
//
// Optional feature:
//   COREIR_MEM_BYPASS_EN - when defined, a read accepted on the same edge as a
//   write to the same address returns the post-write merged word; otherwise it
//   returns the pre-write word.
// -----------------------------------------------------------------------------
module coreir_mem_rv #(
    parameter int unsigned            width        = 16,
    parameter int unsigned            depth        = 16,
    parameter int unsigned            read_latency = 1,
    parameter bit                     has_init     = 1'b0,
    parameter logic [width*depth-1:0] init         = '0
) (
    input logic            clk,
    input logic            rst_n,
    coreir_mem_rv_if.slave bus
);
    localparam int unsigned addr_w = $clog2(depth);
    localparam int unsigned fifo_n = read_latency + 1;
    localparam int unsigned cnt_w  = $clog2(fifo_n + 1);
    localparam int unsigned ptr_w  = $clog2(fifo_n);

    typedef logic [width-1:0] word_t;
    typedef word_t mem_t [depth];

    function automatic mem_t init_image();
        mem_t img;
        for (int j = 0; j < depth; j++) begin
            img[j] = has_init ? init[j*width +: width] : 'x;
        end
        return img;
    endfunction

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(fifo_n - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: the array has no reset branch on purpose; contents survive rst_n
    // and the power-up image comes only from the declaration initialiser.
    mem_t mem_q = init_image();

    logic              rst_n_q;
    logic              accept;
    logic              pop;
    logic              push;
    word_t             merged_w;
    word_t             rd_word;

    word_t             pipe_data_q [read_latency];
    logic [read_latency-1:0] pipe_vld_q;

    word_t             fifo_q [fifo_n];
    logic [ptr_w-1:0]  wr_ptr_q, rd_ptr_q;
    logic [cnt_w-1:0]  fifo_cnt_q;
    logic [cnt_w-1:0]  cnt_q;

    // Ready looks only at registered state, so there is no path from
    // rresp_ready or rreq_valid into rreq_ready.
    assign bus.rreq_ready  = rst_n_q && (cnt_q < cnt_w'(fifo_n));
    assign bus.rresp_valid = (fifo_cnt_q != '0);
    assign bus.rdata       = bus.rresp_valid ? fifo_q[rd_ptr_q] : '0;

    assign accept = bus.rreq_valid && bus.rreq_ready;
    assign pop    = bus.rresp_valid && bus.rresp_ready;
    assign push   = pipe_vld_q[read_latency-1];

    assign merged_w = (mem_q[bus.waddr] & ~bus.wmask) | (bus.wdata & bus.wmask);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rd_word = mem_q[bus.raddr];
`ifdef COREIR_MEM_BYPASS_EN
        if (rst_n && bus.wen && (bus.waddr == bus.raddr)) begin
            rd_word = merged_w;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst_n && bus.wen) begin
            mem_q[bus.waddr] <= merged_w;
        end
    end

    always_ff @(posedge clk) begin
        rst_n_q <= rst_n;
    end

    // Read pipeline: data path unreset, valids cleared so in-flight reads die.
    always_ff @(posedge clk) begin
        pipe_data_q[0] <= rd_word;
        for (int i = 1; i < read_latency; i++) begin
            pipe_data_q[i] <= pipe_data_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q[0] <= accept;
            for (int i = 1; i < read_latency; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
            end
        end
    end

    // Response FIFO. Credits guarantee a push never meets a full FIFO.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= pipe_data_q[read_latency-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            cnt_q      <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);

            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase

            // Credit covers both in-flight pipeline slots and stored responses.
            case ({accept, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: tb/tb_coreir_mem_rv.sv
// -----------------------------------------------------------------------------
// tb_coreir_mem_rv
// Self-checking bench for coreir_mem_rv (width 16, depth 16, read_latency 2,
// initial image on words 0..3). A reference memory model feeds a scoreboard
// queue on every accepted read; a monitor pops and compares on every response
// handshake. Directed scenarios additionally compare recorded responses
// against fixed values.
// -----------------------------------------------------------------------------
module tb_coreir_mem_rv;
    localparam int unsigned W  = 16;
    localparam int unsigned D  = 16;
    localparam int unsigned L  = 2;
    localparam logic [W*D-1:0] INIT = {{12{16'h0000}}, 16'd11, 16'd21, 16'd0, 16'd5};

    logic clk;
    logic rst_n;

    coreir_mem_rv_if #(.width(W), .depth(D)) bus ();

    coreir_mem_rv #(
        .width(W), .depth(D), .read_latency(L), .has_init(1'b1), .init(INIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    logic [W-1:0] model [D];
    logic [W-1:0] sb_q [$];
    logic [W-1:0] got_q [$];
    int           resp_cnt = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_rdata;

    initial begin
        for (int j = 0; j < D; j++) model[j] = INIT[j*W +: W];
    end

    // Inputs change at posedge+1, so the negedge sees the values the next
    // rising edge will act on.
    always @(negedge clk) begin
        logic [W-1:0] rv;
        if (!rst_n) begin
            sb_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && bus.rresp_valid)
                check("rdata_hold", {16'h0, bus.rdata}, {16'h0, prev_rdata});
            prev_stall = bus.rresp_valid && !bus.rresp_ready;
            prev_rdata = bus.rdata;

            if (bus.rresp_valid && bus.rresp_ready) begin
                if (sb_q.size() == 0) begin
                    check("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    rv = sb_q.pop_front();
                    check("rdata", {16'h0, bus.rdata}, {16'h0, rv});
                end
                got_q.push_back(bus.rdata);
                resp_cnt++;
            end

            if (bus.rreq_valid && bus.rreq_ready) begin
                rv = model[bus.raddr];
`ifdef COREIR_MEM_BYPASS_EN
                if (bus.wen && bus.waddr == bus.raddr)
                    rv = (rv & ~bus.wmask) | (bus.wdata & bus.wmask);
`endif
                sb_q.push_back(rv);
            end

            if (bus.wen)
                model[bus.waddr] = (model[bus.waddr] & ~bus.wmask) | (bus.wdata & bus.wmask);
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds rreq_valid until the request is taken; leaves valid asserted.
    task automatic read_req(input int a);
        logic taken;
        taken = 1'b0;
        bus.rreq_valid = 1'b1;
        bus.raddr = 4'(a);
        for (int n = 0; n < 200 && !taken; n++) begin
            taken = bus.rreq_ready;
            tick();
        end
        if (!taken) check("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic write_word(input int a, input logic [W-1:0] d, input logic [W-1:0] m);
        bus.wen = 1'b1;
        bus.waddr = 4'(a);
        bus.wdata = d;
        bus.wmask = m;
        tick();
        bus.wen = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        bus.rreq_valid = 1'b0;
        bus.rresp_ready = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            if (sb_q.size() == 0 && !bus.rresp_valid) done = 1'b1;
            else tick();
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int acc;
        int cyc;
        logic [W-1:0] v;

        rst_n = 1'b0;
        bus.wen = 1'b0;  bus.waddr = '0; bus.wdata = '0; bus.wmask = '0;
        bus.rreq_valid = 1'b0; bus.raddr = '0; bus.rresp_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_rreq_ready", {31'd0, bus.rreq_ready}, 32'd0);
        check("rst_rresp_valid", {31'd0, bus.rresp_valid}, 32'd0);
        check("rst_rdata", {16'h0, bus.rdata}, 32'd0);
        rst_n = 1'b1;
        check("rel_ready_not_yet", {31'd0, bus.rreq_ready}, 32'd0);
        tick();
        check("rel_ready", {31'd0, bus.rreq_ready}, 32'd1);

        // Initial image, back-to-back reads, first-response latency
        bus.rresp_ready = 1'b1;
        got_q.delete();
        read_req(0);
        check("lat_k", {31'd0, bus.rresp_valid}, 32'd0);
        read_req(1);
        check("lat_k1", {31'd0, bus.rresp_valid}, 32'd0);
        read_req(2);
        check("lat_k2", {31'd0, bus.rresp_valid}, 32'd1);
        check("lat_k2_data", {16'h0, bus.rdata}, 32'd5);
        read_req(3);
        drain();
        check("init_count", got_q.size(), 32'd4);
        if (got_q.size() == 4) begin
            check("init_w0", {16'h0, got_q[0]}, 32'd5);
            check("init_w1", {16'h0, got_q[1]}, 32'd0);
            check("init_w2", {16'h0, got_q[2]}, 32'd21);
            check("init_w3", {16'h0, got_q[3]}, 32'd11);
        end

        // Masked write
        write_word(3, 16'hFFFF, 16'hFFFF);
        write_word(3, 16'h1234, 16'h00FF);
        got_q.delete();
        read_req(3);
        drain();
        check("mask_count", got_q.size(), 32'd1);
        if (got_q.size() != 0) check("mask_data", {16'h0, got_q[0]}, 32'h0000FF34);

        // Backpressure: only read_latency+1 requests fit
        got_q.delete();
        bus.rresp_ready = 1'b0;
        acc = 0;
        bus.rreq_valid = 1'b1;
        bus.raddr = 4'(acc);
        for (int n = 0; n < 10; n++) begin
            if (bus.rreq_ready) begin
                acc++;
                tick();
                bus.raddr = 4'(acc);
                if (acc == 5) bus.rreq_valid = 1'b0;
            end else begin
                tick();
            end
        end
        check("bp_accepted", acc, 32'd3);
        check("bp_ready_low", {31'd0, bus.rreq_ready}, 32'd0);
        check("bp_valid_held", {31'd0, bus.rresp_valid}, 32'd1);
        bus.rresp_ready = 1'b1;
        for (int n = 0; n < 50 && acc < 5; n++) begin
            if (bus.rreq_ready) acc++;
            tick();
            bus.raddr = 4'(acc);
            if (acc == 5) bus.rreq_valid = 1'b0;
        end
        check("bp_total", acc, 32'd5);
        drain();
        check("bp_count", got_q.size(), 32'd5);
        if (got_q.size() == 5) begin
            check("bp_r0", {16'h0, got_q[0]}, 32'd5);
            check("bp_r3", {16'h0, got_q[3]}, 32'h0000FF34);
            check("bp_r4", {16'h0, got_q[4]}, 32'd0);
        end

        // Same-edge collision on address 5
        got_q.delete();
        bus.wen = 1'b1; bus.waddr = 4'd5; bus.wdata = 16'hABCD; bus.wmask = 16'hFFFF;
        read_req(5);
        bus.wen = 1'b0;
        read_req(5);
        drain();
        check("coll_count", got_q.size(), 32'd2);
        if (got_q.size() == 2) begin
`ifdef COREIR_MEM_BYPASS_EN
            check("coll_same_edge", {16'h0, got_q[0]}, 32'h0000ABCD);
`else
            check("coll_same_edge", {16'h0, got_q[0]}, 32'h00000000);
`endif
            check("coll_later", {16'h0, got_q[1]}, 32'h0000ABCD);
        end

        // Reset mid-burst with two reads in flight
        got_q.delete();
        read_req(3);
        read_req(5);
        bus.rreq_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        check("midrst_valid", {31'd0, bus.rresp_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        repeat (4) begin
            tick();
            check("midrst_no_stale", {31'd0, bus.rresp_valid}, 32'd0);
        end
        check("midrst_got", got_q.size(), 32'd0);
        read_req(3);
        read_req(5);
        drain();
        check("midrst_count", got_q.size(), 32'd2);
        if (got_q.size() == 2) begin
            check("midrst_keep3", {16'h0, got_q[0]}, 32'h0000FF34);
            check("midrst_keep5", {16'h0, got_q[1]}, 32'h0000ABCD);
        end

        // Streaming: 64 random reads, random backpressure, random writes
        resp_cnt = 0;
        acc = 0;
        cyc = 0;
        bus.rreq_valid = 1'b1;
        bus.raddr = 4'($urandom_range(0, D - 1));
        while (acc < 64 && cyc < 2000) begin
            bus.rresp_ready = 1'($urandom_range(0, 1));
            bus.wen = 1'($urandom_range(0, 1));
            bus.waddr = 4'($urandom_range(0, D - 1));
            v = 16'($urandom);
            bus.wdata = v;
            bus.wmask = 16'($urandom);
            if (bus.rreq_ready) begin
                acc++;
                tick();
                bus.raddr = 4'($urandom_range(0, D - 1));
            end else begin
                tick();
            end
            cyc++;
        end
        bus.wen = 1'b0;
        check("stream_accepted", acc, 32'd64);
        drain();
        check("stream_resp_count", resp_cnt, 32'd64);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
